// File: rtl/muldiv_pkg.sv
// Shared encodings for the MULT/DIV/MTHI/MTLO sequencer: op codes, FSM states
// and the unit-select flag.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ISSUE  = 2'b01,
        ST_WAIT   = 2'b10,
        ST_COMMIT = 2'b11
    } state_t;

    typedef enum logic {
        SEL_MULT = 1'b0,
        SEL_DIV  = 1'b1
    } sel_t;

    // MULT and DIV occupy the lower half of the op space and need a unit.
    function automatic logic is_unit_op(input logic [1:0] op);
        return (op[1] == 1'b0);
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Bundle between control unit / multiplier / divider (master) and the
// sequencer (slave).
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
) ();
    logic             op_valid;
    logic [1:0]       op_code;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             stall;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             mult_start;
    logic [WIDTH-1:0] mult_a;
    logic [WIDTH-1:0] mult_b;
    logic [WIDTH-1:0] mult_hi;
    logic [WIDTH-1:0] mult_lo;
    logic             mult_done;
    logic             div_start;
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_b;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;
    logic             div_done;
    logic             timeout_err;
    logic             div_zero;

    modport slave (
        input  op_valid, op_code, op_a, op_b,
        input  mult_hi, mult_lo, mult_done, div_hi, div_lo, div_done,
        output stall, hi_out, lo_out,
        output mult_start, mult_a, mult_b, div_start, div_a, div_b,
        output timeout_err, div_zero
    );

    modport master (
        output op_valid, op_code, op_a, op_b,
        output mult_hi, mult_lo, mult_done, div_hi, div_lo, div_done,
        input  stall, hi_out, lo_out,
        input  mult_start, mult_a, mult_b, div_start, div_a, div_b,
        input  timeout_err, div_zero
    );
endinterface

// File: rtl/muldiv_watchdog.sv
// Saturating cycle counter with synchronous clear; terminal flags when the
// count has reached TIMEOUT_CYCLES.
module muldiv_watchdog #(
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] r_count_r;

    // Count while enabled, hold at the limit, clear on request.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count_r <= {CW{1'b0}};
        end else if (i_clear) begin
            r_count_r <= {CW{1'b0}};
        end else if (i_enable && (r_count_r != LIMIT)) begin
            r_count_r <= r_count_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            r_count_r <= r_count_r;
        end
    end

    assign o_terminal = (r_count_r == LIMIT);

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences the iterative multiplier/divider and owns architectural HI/LO.
// Optional feature macro: DIVZERO_CHECK_EN (reject DIV by zero without starting the divider).
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic               clock,
    input  logic               reset_n,
    muldiv_sequencer_if.slave  bus
);
    state_t           r_state_r;
    sel_t             r_sel_r;
    logic [WIDTH-1:0] r_hi_r;
    logic [WIDTH-1:0] r_lo_r;
    logic [WIDTH-1:0] r_mult_a_r;
    logic [WIDTH-1:0] r_mult_b_r;
    logic [WIDTH-1:0] r_div_a_r;
    logic [WIDTH-1:0] r_div_b_r;
    logic             r_mult_start_r;
    logic             r_div_start_r;
    logic             r_timeout_err_r;
    logic             r_div_zero_r;

    logic w_div_by_zero_s;
    logic w_sel_done_s;
    logic w_wd_terminal_s;
    logic w_idle_s;

`ifdef DIVZERO_CHECK_EN
    assign w_div_by_zero_s = bus.op_valid && (bus.op_code == OP_DIV) && (bus.op_b == {WIDTH{1'b0}});
`else
    assign w_div_by_zero_s = 1'b0;
`endif

    assign w_idle_s     = (r_state_r == ST_IDLE);
    assign w_sel_done_s = (r_sel_r == SEL_MULT) ? bus.mult_done : bus.div_done;

    muldiv_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_clear    (r_state_r == ST_ISSUE),
        .i_enable   (r_state_r == ST_WAIT),
        .o_terminal (w_wd_terminal_s)
    );

    // Sequencer FSM with operand latches, start pulses and HI/LO.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state_r       <= ST_IDLE;
            r_sel_r         <= SEL_MULT;
            r_hi_r          <= {WIDTH{1'b0}};
            r_lo_r          <= {WIDTH{1'b0}};
            r_mult_a_r      <= {WIDTH{1'b0}};
            r_mult_b_r      <= {WIDTH{1'b0}};
            r_div_a_r       <= {WIDTH{1'b0}};
            r_div_b_r       <= {WIDTH{1'b0}};
            r_mult_start_r  <= 1'b0;
            r_div_start_r   <= 1'b0;
            r_timeout_err_r <= 1'b0;
            r_div_zero_r    <= 1'b0;
        end else begin
            r_mult_start_r  <= 1'b0;
            r_div_start_r   <= 1'b0;
            r_timeout_err_r <= 1'b0;
            r_div_zero_r    <= 1'b0;
            case (r_state_r)
                ST_IDLE: begin
                    if (bus.op_valid) begin
                        case (bus.op_code)
                            OP_MULT: begin
                                r_mult_a_r     <= bus.op_a;
                                r_mult_b_r     <= bus.op_b;
                                r_sel_r        <= SEL_MULT;
                                r_mult_start_r <= 1'b1;
                                r_state_r      <= ST_ISSUE;
                            end
                            OP_DIV: begin
                                if (w_div_by_zero_s) begin
                                    r_div_zero_r <= 1'b1;
                                end else begin
                                    r_div_a_r     <= bus.op_a;
                                    r_div_b_r     <= bus.op_b;
                                    r_sel_r       <= SEL_DIV;
                                    r_div_start_r <= 1'b1;
                                    r_state_r     <= ST_ISSUE;
                                end
                            end
                            OP_MTHI: r_hi_r <= bus.op_a;
                            OP_MTLO: r_lo_r <= bus.op_a;
                            default: r_state_r <= ST_IDLE;
                        endcase
                    end else begin
                        r_state_r <= ST_IDLE;
                    end
                end
                // Done is stale during ISSUE, so it is not looked at here.
                ST_ISSUE: r_state_r <= ST_WAIT;
                ST_WAIT: begin
                    if (w_sel_done_s) begin
                        r_state_r <= ST_COMMIT;
                    end else if (w_wd_terminal_s) begin
                        r_timeout_err_r <= 1'b1;
                        r_state_r       <= ST_IDLE;
                    end else begin
                        r_state_r <= ST_WAIT;
                    end
                end
                ST_COMMIT: begin
                    if (r_sel_r == SEL_MULT) begin
                        r_hi_r <= bus.mult_hi;
                        r_lo_r <= bus.mult_lo;
                    end else begin
                        r_hi_r <= bus.div_hi;
                        r_lo_r <= bus.div_lo;
                    end
                    r_state_r <= ST_IDLE;
                end
                default: r_state_r <= ST_IDLE;
            endcase
        end
    end

    // The CPU must see the stall in the same cycle it presents a unit op.
    assign bus.stall = !w_idle_s ||
                       (bus.op_valid && is_unit_op(bus.op_code) && !w_div_by_zero_s);

    assign bus.hi_out      = r_hi_r;
    assign bus.lo_out      = r_lo_r;
    assign bus.mult_start  = r_mult_start_r;
    assign bus.mult_a      = r_mult_a_r;
    assign bus.mult_b      = r_mult_b_r;
    assign bus.div_start   = r_div_start_r;
    assign bus.div_a       = r_div_a_r;
    assign bus.div_b       = r_div_b_r;
    assign bus.timeout_err = r_timeout_err_r;
    assign bus.div_zero    = r_div_zero_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed plus randomized bench for muldiv_sequencer with behavioural
// multiplier/divider models and an arithmetic HI/LO reference.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int W        = 32;
    localparam int TMO      = 40;
    localparam int MULT_LAT = 33;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    muldiv_sequencer_if #(.WIDTH(W)) bus ();

    muldiv_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(TMO)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Behavioural units: latency countdown after start, done level held.
    logic         m_done = 1'b0, d_done = 1'b0, m_stuck = 1'b0;
    int           m_cnt = 0, d_cnt = 0;
    logic [W-1:0] m_a = '0, m_b = '0, d_a = '0, d_b = '0;
    logic [W-1:0] m_hi = '0, m_lo = '0, d_hi = '0, d_lo = '0;
    int           mult_starts = 0, div_starts = 0;

    always @(posedge clk) begin
        if (bus.mult_start) begin
            mult_starts <= mult_starts + 1;
            m_done <= 1'b0; m_cnt <= MULT_LAT; m_a <= bus.mult_a; m_b <= bus.mult_b;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1 && !m_stuck) begin
                m_done <= 1'b1;
                {m_hi, m_lo} <= {32'd0, m_a} * {32'd0, m_b};
            end
        end
        if (bus.div_start) begin
            div_starts <= div_starts + 1;
            d_done <= 1'b0; d_cnt <= $urandom_range(36, 4); d_a <= bus.div_a; d_b <= bus.div_b;
        end else if (d_cnt != 0) begin
            d_cnt <= d_cnt - 1;
            if (d_cnt == 1) begin
                d_done <= 1'b1;
                d_lo <= (d_b == '0) ? '1 : d_a / d_b;
                d_hi <= (d_b == '0) ? d_a : d_a % d_b;
            end
        end
    end

    assign bus.mult_done = m_done;
    assign bus.mult_hi   = m_hi;
    assign bus.mult_lo   = m_lo;
    assign bus.div_done  = d_done;
    assign bus.div_hi    = d_hi;
    assign bus.div_lo    = d_lo;

    logic [W-1:0] exp_hi = '0, exp_lo = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: what HI/LO must hold after an op completes.
    task automatic model_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] p;
        case (op)
            OP_MULT: begin p = 64'(a) * 64'(b); exp_hi = p[63:32]; exp_lo = p[31:0]; end
            OP_DIV: begin
`ifdef DIVZERO_CHECK_EN
                if (b != '0) begin exp_hi = a % b; exp_lo = a / b; end
`else
                if (b == '0) begin exp_hi = a; exp_lo = '1; end
                else begin exp_hi = a % b; exp_lo = a / b; end
`endif
            end
            OP_MTHI: exp_hi = a;
            default: exp_lo = a;
        endcase
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int  m0, d0, n;
        logic unit;
        m0 = mult_starts; d0 = div_starts;
        unit = (op == OP_MULT) || (op == OP_DIV);
`ifdef DIVZERO_CHECK_EN
        if (op == OP_DIV && b == '0) unit = 1'b0;
`endif
        bus.op_valid = 1'b1; bus.op_code = op; bus.op_a = a; bus.op_b = b;
        #1;
        chk({tag, ".stall_on_present"}, 64'(bus.stall), 64'(unit));
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        model_op(op, a, b);
        if (!unit && op == OP_DIV)
            chk({tag, ".div_zero"}, 64'(bus.div_zero), 64'd1);
        n = 0;
        while (bus.stall && n < 200) begin tick(); n++; end
        chk({tag, ".stall_released"}, 64'(bus.stall), 64'd0);
        chk({tag, ".mult_starts"}, 64'(mult_starts - m0), 64'((op == OP_MULT) ? 1 : 0));
        chk({tag, ".div_starts"}, 64'(div_starts - d0), 64'((op == OP_DIV && unit) ? 1 : 0));
        chk({tag, ".hilo"}, {bus.hi_out, bus.lo_out}, {exp_hi, exp_lo});
    endtask

    initial begin
        int n;
        logic [1:0]   op;
        logic [W-1:0] a, b;
        bus.op_valid = 1'b0; bus.op_code = 2'b00; bus.op_a = '0; bus.op_b = '0;
        #12;
        chk("reset_outputs", {bus.stall, bus.hi_out, bus.lo_out, bus.mult_start, bus.div_start,
             bus.timeout_err, bus.div_zero, bus.mult_a | bus.mult_b | bus.div_a | bus.div_b}, 64'd0);
        rst_n = 1'b1;
        tick();

        run_op("mult7x6", OP_MULT, 32'd7, 32'd6);
        chk("mult7x6.lo42", 64'(bus.lo_out), 64'd42);
        run_op("div100by7", OP_DIV, 32'd100, 32'd7);
        chk("div100by7.q_r", {bus.hi_out, bus.lo_out}, {32'd2, 32'd14});

        // MTHI: visible one cycle later, never stalls.
        bus.op_valid = 1'b1; bus.op_code = OP_MTHI; bus.op_a = 32'hDEADBEEF; #1;
        chk("mthi.no_stall", 64'(bus.stall), 64'd0);
        @(posedge clk); #1; bus.op_valid = 1'b0; exp_hi = 32'hDEADBEEF;
        chk("mthi.hi", 64'(bus.hi_out), 64'hDEADBEEF);
        run_op("mtlo", OP_MTLO, 32'h12345678, 32'hFFFF0000);

        // Op re-presented during WAIT must not disturb the latched operands.
        bus.op_valid = 1'b1; bus.op_code = OP_MULT; bus.op_a = 32'hFFFF_FFFF; bus.op_b = 32'd3;
        tick();
        bus.op_a = 32'd11; bus.op_b = 32'd13;
        for (int i = 0; i < 6; i++) tick();
        bus.op_valid = 1'b0;
        chk("redrive.operands", {bus.mult_a, bus.mult_b}, {32'hFFFF_FFFF, 32'd3});
        n = 0;
        while (bus.stall && n < 200) begin tick(); n++; end
        model_op(OP_MULT, 32'hFFFF_FFFF, 32'd3);
        chk("redrive.hilo", {bus.hi_out, bus.lo_out}, {exp_hi, exp_lo});

        // Watchdog: stuck multiplier.
        m_stuck = 1'b1;
        bus.op_valid = 1'b1; bus.op_code = OP_MULT; bus.op_a = 32'd5; bus.op_b = 32'd5;
        tick(); bus.op_valid = 1'b0;
        n = 0;
        while (!bus.timeout_err && n < 100) begin tick(); n++; end
        chk("timeout.latency", 64'(n), 64'(TMO + 2));
        chk("timeout.stall_drop", 64'(bus.stall), 64'd0);
        tick();
        chk("timeout.pulse_1cyc", 64'(bus.timeout_err), 64'd0);
        chk("timeout.hilo_kept", {bus.hi_out, bus.lo_out}, {exp_hi, exp_lo});
        for (int i = 0; i < 5; i++) tick();
        m_stuck = 1'b0;

        // Randomized ops against the arithmetic reference.
        for (int i = 0; i < 12; i++) begin
            op = 2'($urandom_range(3, 0));
            a = $urandom;
            b = (i % 5 == 4) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(300, 1)) : $urandom);
            run_op($sformatf("rand%0d", i), op, a, b);
        end

        // Reset in the middle of WAIT; late done must be ignored.
        bus.op_valid = 1'b1; bus.op_code = OP_MULT; bus.op_a = 32'd9; bus.op_b = 32'd9;
        tick(); bus.op_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0; #1;
        chk("midreset.outputs", {bus.stall, bus.hi_out, bus.lo_out, bus.mult_start, bus.div_start,
             bus.timeout_err, bus.div_zero, bus.mult_a | bus.mult_b | bus.div_a | bus.div_b}, 64'd0);
        tick(); tick();
        rst_n = 1'b1; exp_hi = '0; exp_lo = '0;
        for (int i = 0; i < 40; i++) tick();
        chk("late_done.ignored", {31'd0, bus.stall, bus.hi_out}, {32'd0, 32'd0});
        chk("late_done.lo", 64'(bus.lo_out), 64'd0);
        run_op("div_by_zero", OP_DIV, 32'h0000_BEEF, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
